// File: rtl/lsu_if.sv
// Word-addressed memory port between the load/store unit (master) and memory (slave).
interface lsu_if #(
  parameter int REG_W = 32
);
  logic             mem_reqValid;
  logic             mem_reqReady;
  logic             mem_wen;
  logic [REG_W-1:0] mem_addr;
  logic [REG_W-1:0] mem_wdata;
  logic [3:0]       mem_wmask;
  logic             mem_respValid;
  logic [REG_W-1:0] mem_rdata;

  modport master (
    output mem_reqValid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    input  mem_reqReady, mem_respValid, mem_rdata
  );

  modport slave (
    input  mem_reqValid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    output mem_reqReady, mem_respValid, mem_rdata
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: byte-lane shifting/masking for stores, extraction/extension for loads.
// Optional LSU_MISALIGN_TRAP_EN: misaligned requests fault without any memory traffic.
//
// state    | meaning
// LSU_IDLE | waiting for reqValid; decodes and registers the memory request
// LSU_REQ  | mem_reqValid held with stable mem_* until mem_reqReady
// LSU_WAIT | waiting for read data or write acknowledge
// LSU_RESP | respValid pulse, rdata/fault valid
module lsu #(
  parameter int REG_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             reqValid,
  input  logic             is_store,
  input  logic [1:0]       size,
  input  logic             is_unsigned,
  input  logic [REG_W-1:0] addr,
  input  logic [REG_W-1:0] wdata,
  output logic             respValid,
  output logic [REG_W-1:0] rdata,
  output logic             fault,
  lsu_if.master            mem
);

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_RESP
  } state_t;

  state_t     state;
  logic       is_unsigned_q;
  logic [1:0] size_q;
  logic [1:0] off_q;

  logic             sz_b;
  logic             sz_h;
  logic [1:0]       off;
  logic [3:0]       wmask_d;
  logic [REG_W-1:0] wdata_d;
  logic             trap_hit;

  // Offset is rounded down to the natural alignment; only matters when trapping is off.
  always_comb begin
    sz_b = (size == 2'd0);
    sz_h = (size == 2'd1);
    off  = addr[1:0];
    if (sz_h) begin
      off[0] = 1'b0;
    end else if (!sz_b) begin
      off = 2'b00;
    end
    if (sz_b) begin
      wmask_d = 4'b0001 << off;
      wdata_d = {4{wdata[7:0]}};
    end else if (sz_h) begin
      wmask_d = 4'b0011 << off;
      wdata_d = {2{wdata[15:0]}};
    end else begin
      wmask_d = 4'b1111;
      wdata_d = wdata;
    end
`ifdef LSU_MISALIGN_TRAP_EN
    trap_hit = (sz_h && addr[0]) || (!sz_b && !sz_h && (addr[1:0] != 2'b00));
`else
    trap_hit = 1'b0;
`endif
  end

  logic [REG_W-1:0] lane_w;
  logic [REG_W-1:0] load_d;

  always_comb begin
    lane_w = mem.mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    load_d = is_unsigned_q ? {{(REG_W-8){1'b0}}, lane_w[7:0]}
                                      : {{(REG_W-8){lane_w[7]}}, lane_w[7:0]};
      2'd1:    load_d = is_unsigned_q ? {{(REG_W-16){1'b0}}, lane_w[15:0]}
                                      : {{(REG_W-16){lane_w[15]}}, lane_w[15:0]};
      default: load_d = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= LSU_IDLE;
      respValid        <= 1'b0;
      rdata            <= '0;
      fault            <= 1'b0;
      is_unsigned_q    <= 1'b0;
      size_q           <= 2'd0;
      off_q            <= 2'd0;
      mem.mem_reqValid <= 1'b0;
      mem.mem_wen      <= 1'b0;
      mem.mem_addr     <= '0;
      mem.mem_wdata    <= '0;
      mem.mem_wmask    <= 4'b0000;
    end else begin
      case (state)
        LSU_IDLE: begin
          respValid <= 1'b0;
          if (reqValid) begin
            fault         <= trap_hit;
            rdata         <= '0;
            is_unsigned_q <= is_unsigned;
            size_q        <= size;
            off_q         <= off;
            if (trap_hit) begin
              respValid <= 1'b1;
              state     <= LSU_RESP;
            end else begin
              mem.mem_reqValid <= 1'b1;
              mem.mem_wen      <= is_store;
              mem.mem_addr     <= {addr[REG_W-1:2], 2'b00};
              mem.mem_wdata    <= wdata_d;
              mem.mem_wmask    <= wmask_d;
              state            <= LSU_REQ;
            end
          end
        end
        LSU_REQ: begin
          if (mem.mem_reqReady) begin
            mem.mem_reqValid <= 1'b0;
            state            <= LSU_WAIT;
          end
        end
        LSU_WAIT: begin
          if (mem.mem_respValid) begin
            rdata     <= mem.mem_wen ? '0 : load_d;
            respValid <= 1'b1;
            state     <= LSU_RESP;
          end
        end
        LSU_RESP: begin
          respValid <= 1'b0;
          state     <= LSU_IDLE;
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: byte-addressed reference memory predicts results, a memory
// responder checks the word port, and a monitor pops expectations on every respValid.
module tb_lsu;
  logic        clock = 1'b0;
  logic        reset;
  logic        reqValid;
  logic        is_store;
  logic [1:0]  size;
  logic        is_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        respValid;
  logic [31:0] rdata;
  logic        fault;

  lsu_if #(.REG_W(32)) mem ();

  lsu #(.REG_W(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .reqValid    (reqValid),
    .is_store    (is_store),
    .size        (size),
    .is_unsigned (is_unsigned),
    .addr        (addr),
    .wdata       (wdata),
    .respValid   (respValid),
    .rdata       (rdata),
    .fault       (fault),
    .mem         (mem)
  );

  always #5 clock = ~clock;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mtx_t;

  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];
  mtx_t mq[$];

  logic [7:0]  ref_mem[64];
  logic [31:0] mem_words[16];

  int force_low  = 0;
  bit rdy_always = 1'b1;
  int resp_fixed = 0;
  bit stray_en   = 1'b0;
  int hs_count   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] word);
    for (int i = 0; i < 4; i++) ref_mem[(a[5:0] & 6'h3c) + i] = word[8*i +: 8];
    mem_words[a[5:2]] = word;
  endtask

  // Monitor: every respValid consumes exactly one expectation.
  initial begin : monitor
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if (respValid) begin
        check("resp_single_cycle", {127'd0, prev}, 128'd0);
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: respValid=1 with nothing outstanding at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          check("rdata", {96'd0, rdata}, {96'd0, e.rdata});
          check("fault", {127'd0, fault}, {127'd0, e.fault});
        end
      end
      prev = respValid;
    end
  end

  // Memory responder: word-addressed store, checks each accepted request and holds during stalls.
  initial begin : responder
    int          resp_cnt;
    logic [31:0] resp_word;
    bit          pend;
    logic [68:0] snap;
    mtx_t        m;
    int          idx;
    resp_cnt = -1;
    resp_word = '0;
    pend = 1'b0;
    snap = '0;
    mem.mem_reqReady  = 1'b0;
    mem.mem_respValid = 1'b0;
    mem.mem_rdata     = '0;
    forever begin
      @(negedge clock);
      mem.mem_respValid = 1'b0;
      mem.mem_rdata     = $urandom;
      if (resp_cnt == 0) begin
        mem.mem_respValid = 1'b1;
        mem.mem_rdata     = resp_word;
        resp_cnt          = -1;
      end else if (resp_cnt > 0) begin
        resp_cnt--;
      end else if (stray_en && $urandom_range(0, 7) == 0) begin
        mem.mem_respValid = 1'b1;
      end
      if (pend && !reset)
        check("req_hold", {58'd0, mem.mem_reqValid, mem.mem_wen, mem.mem_addr, mem.mem_wdata, mem.mem_wmask},
              {58'd0, 1'b1, snap});
      if (force_low > 0) begin
        mem.mem_reqReady = 1'b0;
        force_low--;
      end else begin
        mem.mem_reqReady = rdy_always ? 1'b1 : ($urandom_range(0, 2) != 0);
      end
      if (mem.mem_reqValid && mem.mem_reqReady && !reset) begin
        hs_count++;
        pend = 1'b0;
        if (mq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_mem_req: mem_reqValid=1 addr=%0h with no request expected", mem.mem_addr);
        end else begin
          m = mq.pop_front();
          check("mem_wen", {127'd0, mem.mem_wen}, {127'd0, m.wen});
          check("mem_addr", {96'd0, mem.mem_addr}, {96'd0, m.addr});
          if (m.wen) begin
            check("mem_wmask", {124'd0, mem.mem_wmask}, {124'd0, m.wmask});
            check("mem_wdata", {96'd0, mem.mem_wdata}, {96'd0, m.wdata});
          end
        end
        idx = int'(mem.mem_addr[5:2]);
        if (mem.mem_wen) begin
          for (int l = 0; l < 4; l++)
            if (mem.mem_wmask[l]) mem_words[idx][8*l +: 8] = mem.mem_wdata[8*l +: 8];
          resp_word = $urandom;
        end else begin
          resp_word = mem_words[idx];
        end
        resp_cnt = (resp_fixed >= 0) ? resp_fixed : $urandom_range(0, 3);
      end else begin
        pend = mem.mem_reqValid;
        snap = {mem.mem_wen, mem.mem_addr, mem.mem_wdata, mem.mem_wmask};
      end
    end
  end

  // Issue one op, predict from the byte-level reference, and return respValid latency in cycles.
  task automatic do_op(input bit st, input logic [1:0] sz, input bit un, input logic [31:0] a,
                       input logic [31:0] wd, input bit use_exp, input logic [31:0] exp_val,
                       input int hold, output int lat);
    int          n;
    logic [31:0] ea;
    longint      v;
    exp_t        e;
    mtx_t        m;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e.fault = 1'b0;
    e.rdata = '0;
    if (TRAP && (a % n) != 0) begin
      e.fault = 1'b1;
    end else begin
      ea = a - (a % n);
      m.wen   = st;
      m.addr  = ea & ~32'h3;
      m.wmask = 4'((1 << n) - 1);
      m.wmask = m.wmask << ea[1:0];
      m.wdata = (n == 1) ? wd[7:0] * 32'h01010101 : (n == 2) ? wd[15:0] * 32'h00010001 : wd;
      mq.push_back(m);
      if (st) begin
        for (int i = 0; i < n; i++) ref_mem[(int'(ea[5:0]) + i) & 63] = 8'(wd >> (8 * i));
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[(int'(ea[5:0]) + i) & 63]) << (8 * i));
        if (!un && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        e.rdata = v[31:0];
      end
    end
    if (use_exp) e.rdata = exp_val;
    sb_q.push_back(e);

    @(posedge clock); #1;
    reqValid = 1'b1; is_store = st; size = sz; is_unsigned = un; addr = a; wdata = wd;
    force_low = hold;
    lat = 0;
    forever begin
      @(posedge clock); #1;
      reqValid = 1'($urandom_range(0, 1));
      is_store = 1'($urandom); size = 2'($urandom); is_unsigned = 1'($urandom);
      addr = $urandom; wdata = $urandom;
      @(negedge clock);
      lat++;
      if (respValid) break;
      if (lat > 300) begin
        total++;
        bad++;
        $display("FAIL op_timeout: no respValid after %0d cycles for addr %0h", lat, a);
        break;
      end
    end
    @(posedge clock); #1;
    reqValid = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {1'b0, respValid, rdata, fault, mem.mem_reqValid, mem.mem_wen, mem.mem_addr,
                 mem.mem_wdata, mem.mem_wmask}, 128'd0);
  endtask

  initial begin : stimulus
    int   lat;
    int   h0;
    mtx_t m;
    reset = 1'b1;
    reqValid = 1'b0; is_store = 1'b0; size = 2'd0; is_unsigned = 1'b0; addr = '0; wdata = '0;
    for (int i = 0; i < 16; i++) preload(32'(i * 4), $urandom);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset_state");
    @(posedge clock); #1;
    reset = 1'b0;

    // Basic word load, minimum latency.
    preload(32'h100, 32'hDEADBEEF);
    do_op(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF, 0, lat);
    check("lw_latency", 128'(lat), 128'd3);

    // Sub-word loads with sign/zero extension.
    preload(32'h100, 32'h80112233);
    do_op(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1'b1, 32'hFFFFFF80, 0, lat);
    do_op(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1'b1, 32'h00000080, 0, lat);
    do_op(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 1'b1, 32'hFFFF8011, 0, lat);
    do_op(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 1'b1, 32'h00008011, 0, lat);

    // Byte store, then read back the whole word.
    do_op(1'b1, 2'd0, 1'b0, 32'h201, 32'h000000AB, 1'b1, 32'h0, 0, lat);
    check("sb_latency", 128'(lat), 128'd3);
    do_op(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 1'b0, 32'h0, 0, lat);

    // Ready held low for five cycles; reqValid junk during the stall is ignored.
    do_op(1'b1, 2'd1, 1'b0, 32'h10E, 32'h1234CAFE, 1'b0, 32'h0, 6, lat);
    check("stall_latency", 128'(lat), 128'd8);

    // Misaligned word load.
    do_op(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 1'b0, 32'h0, 0, lat);
    check("misaligned_latency", 128'(lat), TRAP ? 128'd1 : 128'd3);

    // Reset while waiting for the memory response; the late response must be ignored.
    resp_fixed = 4;
    m.wen = 1'b0; m.addr = 32'h104; m.wdata = '0; m.wmask = '0;
    mq.push_back(m);
    h0 = hs_count;
    @(posedge clock); #1;
    reqValid = 1'b1; is_store = 1'b0; size = 2'd2; is_unsigned = 1'b0; addr = 32'h104;
    @(posedge clock); #1;
    reqValid = 1'b0;
    for (int i = 0; i < 20 && hs_count == h0; i++) @(negedge clock);
    check("reset_test_handshake", 128'(hs_count - h0), 128'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_all_zero("mid_op_reset");
    repeat (8) @(negedge clock);
    check_all_zero("after_late_resp");
    resp_fixed = 0;
    do_op(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 0, lat);
    check("post_reset_latency", 128'(lat), 128'd3);

    // Randomized traffic with random ready/response timing and stray responses.
    rdy_always = 1'b0;
    resp_fixed = -1;
    stray_en   = 1'b1;
    for (int k = 0; k < 300; k++)
      do_op(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, 1'b0, 32'h0, 0, lat);

    stray_en = 1'b0;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clock);
    check("scoreboard_drained", 128'(sb_q.size()), 128'd0);
    check("mem_queue_drained", 128'(mq.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
